calc_sequencer: RTL

- Command sequencer in front of the calculator accumulator datapath (ALU + 16-bit accumulator).
- Accepts a stream of (operation, operand) commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the datapath by driving the op-select lines, the operand and a one-cycle accumulate strobe.
- Returns each post-operation accumulator value on a valid/ready result port. Replaces manual button/switch sequencing.

---
 rtl/calc_sequencer_if.sv | 30 +++
 rtl/calc_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// Bus between the calculator command sequencer (master) and its environment:
// command stream in, datapath controls out, accumulator sample in, results out.
interface calc_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clr;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic [2:0]  alu_op;
    logic [15:0] alu_operand;
    logic        acc_en;
    logic        acc_clr;
    logic [15:0] acc_value;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [15:0] ops_done;

    modport master (
        input  cmd_valid, cmd_clr, cmd_op, cmd_operand, acc_value, res_ready,
        output cmd_ready, alu_op, alu_operand, acc_en, acc_clr,
               res_valid, res_data, ops_done
    );

    modport slave (
        output cmd_valid, cmd_clr, cmd_op, cmd_operand, acc_value, res_ready,
        input  cmd_ready, alu_op, alu_operand, acc_en, acc_clr,
               res_valid, res_data, ops_done
    );
endinterface

// File: rtl/calc_sequencer.sv
// Command sequencer for the calculator accumulator datapath: buffers commands,
// issues them one at a time and returns each post-operation accumulator value.
module calc_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    calc_sequencer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 20;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
    logic [EW-1:0]   entry_q [FIFO_DEPTH];
    logic [EW-1:0]   head;
    logic            fifo_empty, fifo_full, push, pop;
    logic            clr_reg;
    logic [2:0]      alu_op_reg;
    logic [15:0]     alu_operand_reg;
    logic [CW-1:0]   settle_cnt_reg;
    logic [15:0]     res_data_reg;
    logic [15:0]     ops_done_reg;
    logic            last_wait;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push       = bus.cmd_valid && !fifo_full;
    assign pop        = (state_reg == S_IDLE) && !fifo_empty;
    assign head       = entry_q[rd_ptr_reg[AW-1:0]];
    assign last_wait  = (state_reg == S_WAIT) && (settle_cnt_reg == CW'(1));

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [EW-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    data_reg <= {bus.cmd_clr, bus.cmd_op, bus.cmd_operand};
                end
            end

            assign entry_q[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!fifo_empty) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (last_wait) state_next = S_RESP;
            S_RESP:  if (bus.res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Clear commands leave alu_op/alu_operand at their last issued values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_reg         <= 1'b0;
            alu_op_reg      <= 3'd0;
            alu_operand_reg <= 16'd0;
            settle_cnt_reg  <= '0;
            res_data_reg    <= 16'd0;
            ops_done_reg    <= 16'd0;
        end else begin
            if (pop) begin
                clr_reg <= head[19];
                if (!head[19]) begin
                    alu_op_reg      <= head[18:16];
                    alu_operand_reg <= head[15:0];
                end
            end
            if (state_reg == S_ISSUE) begin
                settle_cnt_reg <= CW'(SETTLE_CYCLES);
            end else if (state_reg == S_WAIT) begin
                settle_cnt_reg <= settle_cnt_reg - 1'b1;
            end
            if (last_wait) begin
                res_data_reg <= bus.acc_value;
            end
            if ((state_reg == S_RESP) && bus.res_ready) begin
                ops_done_reg <= ops_done_reg + 16'd1;
            end
        end
    end

    always_comb begin
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.res_valid = 1'b0;
        case (state_reg)
            S_ISSUE: begin
                bus.acc_en  = !clr_reg;
                bus.acc_clr = clr_reg;
            end
            S_RESP:  bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.alu_op      = alu_op_reg;
    assign bus.alu_operand = alu_operand_reg;
    assign bus.res_data    = res_data_reg;
    assign bus.ops_done    = ops_done_reg;
endmodule
